// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Default geometry, the default-depth occupancy type, and the width helpers
// used to size pointers and the occupancy counter for any depth.
package fifo_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  // Occupancy for the default depth: 0..DEF_FIFO_DEPTH inclusive
  typedef logic [$clog2(DEF_FIFO_DEPTH + 1) - 1:0] count_t;

  // Address width for a memory of 'depth' entries (at least one bit)
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to hold 0..depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// FIFO handshake/status bundle.
//   master : producer/consumer side (drives data_in, wr_en, rd_en)
//   slave  : FIFO side (drives read data, pulses, flags and count)
// Parameters must match the sync_fifo_param instance attached to it.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, rd_valid, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
// Ports:
//   clk       : write clock
//   wr_en     : write strobe
//   wr_addr   : write address
//   wr_data   : write data
//   rd_addr   : read address
//   rd_data_c : combinational read data at rd_addr
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read port
  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and one-cycle status pulses.
// Depth need not be a power of two; pointers wrap by explicit compare.
// A write is accepted at full when a read pops in the same cycle.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (deassertion synchronised upstream)
//   bus   : sync_fifo_param_if.slave
//           data_in/wr_en/rd_en in; data_out, rd_valid, wr_ack, overflow,
//           underflow, full, empty, almostfull, almostempty, count out
//
// Build option:
//   FIFO_FWFT_EN : first-word-fall-through; data_out shows the head word
//                  whenever non-empty and rd_valid = !empty. Undefined gives
//                  a registered read with one cycle of latency.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_param_if.slave   bus
);

  localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [FIFO_WIDTH-1:0] mem_rd_data_c;

  logic full_c;
  logic empty_c;
  logic wr_accept_c;
  logic rd_accept_c;

  // Pointer advance with explicit wrap for non-power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Status derived from the registered occupancy
  assign full_c  = (count_q == CNT_FULL);
  assign empty_c = (count_q == '0);

  // A read freeing a slot lets a write at full go through in the same cycle
  assign wr_accept_c = bus.wr_en && (!full_c || bus.rd_en);
  assign rd_accept_c = bus.rd_en && !empty_c;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_accept_c),
    .wr_addr   (wr_ptr),
    .wr_data   (bus.data_in),
    .rd_addr   (rd_ptr),
    .rd_data_c (mem_rd_data_c)
  );

  // Pointers, occupancy and handshake pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_accept_c) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_accept_c) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({wr_accept_c, rd_accept_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      wr_ack_q    <= wr_accept_c;
      overflow_q  <= bus.wr_en && !wr_accept_c;
      underflow_q <= bus.rd_en && empty_c;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; a pop simply advances rd_ptr
  assign bus.data_out = empty_c ? '0 : mem_rd_data_c;
  assign bus.rd_valid = !empty_c;
`else
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  // Registered read: capture the head word on an accepted pop, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (rd_accept_c) begin
        data_out_q <= mem_rd_data_c;
      end
      rd_valid_q <= rd_accept_c;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.almostfull  = (count_q >= CNT_AF);
  assign bus.almostempty = (count_q <= CNT_AE);
  assign bus.count       = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: an 8-deep instance for
// reset/full/empty corner cases and a 6-deep instance for pointer wrap.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) b8 ();
  sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(6)) b6 ();

  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b6)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (b8.count !== count_t'(0)) begin bad++; $display("FAIL rst_count got=%0d want=0", b8.count); end
    total++; if ({b8.full, b8.empty, b8.almostfull, b8.almostempty} !== 4'b0101) begin bad++; $display("FAIL rst_flags got=%b want=0101", {b8.full, b8.empty, b8.almostfull, b8.almostempty}); end
    total++; if ({b8.rd_valid, b8.wr_ack, b8.overflow, b8.underflow} !== 4'b0000) begin bad++; $display("FAIL rst_pulses got=%b want=0000", {b8.rd_valid, b8.wr_ack, b8.overflow, b8.underflow}); end
    total++; if (b8.data_out !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h want=0000", b8.data_out); end
    total++; if ({b6.empty, b6.count} !== {1'b1, 3'd0}) begin bad++; $display("FAIL rst_b6 got=%b want=1000", {b6.empty, b6.count}); end
    #5 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_head;
    for (int i = 0; i < 5; i++) begin
      b8.wr_en = 1'b1; b8.data_in = 16'h0011 + 16'(i);
      step();
    end
    b8.wr_en = 1'b0;
    total++; if (b8.count !== count_t'(5)) begin bad++; $display("FAIL mid_fill_count got=%0d want=5", b8.count); end
    b8.rd_en = 1'b1;
    step();
    b8.rd_en = 1'b0;
`ifdef FIFO_FWFT_EN
    exp_head = 16'h0012;
`else
    exp_head = 16'h0011;
`endif
    total++; if (b8.data_out !== exp_head) begin bad++; $display("FAIL mid_read_data got=%h want=%h", b8.data_out, exp_head); end
    total++; if (b8.rd_valid !== 1'b1) begin bad++; $display("FAIL mid_read_valid got=%b want=1", b8.rd_valid); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (b8.count !== count_t'(0)) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", b8.count); end
    total++; if ({b8.empty, b8.almostempty} !== 2'b11) begin bad++; $display("FAIL mid_rst_flags got=%b want=11", {b8.empty, b8.almostempty}); end
    total++; if (b8.data_out !== 16'h0000) begin bad++; $display("FAIL mid_rst_data got=%h want=0000", b8.data_out); end
    total++; if (b8.rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", b8.rd_valid); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 8; i++) begin
      b8.wr_en = 1'b1; b8.data_in = 16'(i);
      step();
      total++; if (b8.count !== count_t'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, b8.count, i); end
      total++; if ({b8.full, b8.almostfull} !== {(i == 8), (i >= 7)}) begin bad++; $display("FAIL fill_flags[%0d] got=%b want=%b", i, {b8.full, b8.almostfull}, {(i == 8), (i >= 7)}); end
      total++; if (b8.wr_ack !== 1'b1) begin bad++; $display("FAIL fill_ack[%0d] got=%b want=1", i, b8.wr_ack); end
    end
    b8.data_in = 16'h0099;
    step();
    b8.wr_en = 1'b0;
    total++; if ({b8.overflow, b8.wr_ack} !== 2'b10) begin bad++; $display("FAIL ovf_pulse got=%b want=10", {b8.overflow, b8.wr_ack}); end
    total++; if (b8.count !== count_t'(8)) begin bad++; $display("FAIL ovf_count got=%0d want=8", b8.count); end
    step();
    total++; if ({b8.overflow, b8.wr_ack} !== 2'b00) begin bad++; $display("FAIL ovf_clear got=%b want=00", {b8.overflow, b8.wr_ack}); end
  endtask

  task automatic test_full_rw();
    logic [15:0] exp;
`ifdef FIFO_FWFT_EN
    total++; if (b8.data_out !== 16'h0001) begin bad++; $display("FAIL frw_head got=%h want=0001", b8.data_out); end
`endif
    b8.wr_en = 1'b1; b8.rd_en = 1'b1; b8.data_in = 16'h00AA;
    step();
    b8.wr_en = 1'b0; b8.rd_en = 1'b0;
    total++; if ({b8.wr_ack, b8.overflow, b8.full} !== 3'b101) begin bad++; $display("FAIL frw_status got=%b want=101", {b8.wr_ack, b8.overflow, b8.full}); end
    total++; if (b8.count !== count_t'(8)) begin bad++; $display("FAIL frw_count got=%0d want=8", b8.count); end
`ifdef FIFO_FWFT_EN
    exp = 16'h0002;
`else
    exp = 16'h0001;
`endif
    total++; if ({b8.rd_valid, b8.data_out} !== {1'b1, exp}) begin bad++; $display("FAIL frw_pop got=%h want=%h", {b8.rd_valid, b8.data_out}, {1'b1, exp}); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 16'(i + 2) : 16'h00AA;
`ifdef FIFO_FWFT_EN
      total++; if ({b8.rd_valid, b8.data_out} !== {1'b1, exp}) begin bad++; $display("FAIL drain[%0d] got=%h want=%h", i, {b8.rd_valid, b8.data_out}, {1'b1, exp}); end
      b8.rd_en = 1'b1;
      step();
`else
      b8.rd_en = 1'b1;
      step();
      total++; if ({b8.rd_valid, b8.data_out} !== {1'b1, exp}) begin bad++; $display("FAIL drain[%0d] got=%h want=%h", i, {b8.rd_valid, b8.data_out}, {1'b1, exp}); end
`endif
    end
    b8.rd_en = 1'b0;
    total++; if ({b8.empty, b8.count} !== {1'b1, 4'd0}) begin bad++; $display("FAIL drain_empty got=%b want=10000", {b8.empty, b8.count}); end
    step();
`ifdef FIFO_FWFT_EN
    exp = 16'h0000;
`else
    exp = 16'h00AA;
`endif
    total++; if ({b8.rd_valid, b8.data_out} !== {1'b0, exp}) begin bad++; $display("FAIL drain_hold got=%h want=%h", {b8.rd_valid, b8.data_out}, {1'b0, exp}); end
  endtask

  task automatic test_empty_rw();
    logic exp_valid;
    b8.rd_en = 1'b1;
    step();
    b8.rd_en = 1'b0;
    total++; if ({b8.underflow, b8.rd_valid, b8.wr_ack} !== 3'b100) begin bad++; $display("FAIL udf_only got=%b want=100", {b8.underflow, b8.rd_valid, b8.wr_ack}); end
    b8.wr_en = 1'b1; b8.rd_en = 1'b1; b8.data_in = 16'h0055;
    step();
    b8.wr_en = 1'b0; b8.rd_en = 1'b0;
`ifdef FIFO_FWFT_EN
    exp_valid = 1'b1;
`else
    exp_valid = 1'b0;
`endif
    total++; if ({b8.underflow, b8.wr_ack} !== 2'b11) begin bad++; $display("FAIL erw_pulses got=%b want=11", {b8.underflow, b8.wr_ack}); end
    total++; if (b8.count !== count_t'(1)) begin bad++; $display("FAIL erw_count got=%0d want=1", b8.count); end
    total++; if (b8.rd_valid !== exp_valid) begin bad++; $display("FAIL erw_valid got=%b want=%b", b8.rd_valid, exp_valid); end
`ifdef FIFO_FWFT_EN
    total++; if (b8.data_out !== 16'h0055) begin bad++; $display("FAIL erw_read got=%h want=0055", b8.data_out); end
    b8.rd_en = 1'b1;
    step();
    b8.rd_en = 1'b0;
    total++; if ({b8.rd_valid, b8.underflow, b8.empty} !== 3'b001) begin bad++; $display("FAIL erw_after got=%b want=001", {b8.rd_valid, b8.underflow, b8.empty}); end
`else
    b8.rd_en = 1'b1;
    step();
    b8.rd_en = 1'b0;
    total++; if (b8.data_out !== 16'h0055) begin bad++; $display("FAIL erw_read got=%h want=0055", b8.data_out); end
    total++; if ({b8.rd_valid, b8.underflow, b8.empty} !== 3'b101) begin bad++; $display("FAIL erw_after got=%b want=101", {b8.rd_valid, b8.underflow, b8.empty}); end
`endif
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    b8.wr_en = 1'b1; b8.data_in = 16'h1234;
    step();
    b8.wr_en = 1'b0;
    total++; if ({b8.rd_valid, b8.data_out} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL fwft_show got=%h want=11234", {b8.rd_valid, b8.data_out}); end
    b8.rd_en = 1'b1;
    step();
    b8.rd_en = 1'b0;
    total++; if ({b8.empty, b8.rd_valid} !== 2'b10) begin bad++; $display("FAIL fwft_pop got=%b want=10", {b8.empty, b8.rd_valid}); end
  endtask
`else
  task automatic test_read_latency();
    b8.wr_en = 1'b1; b8.data_in = 16'h1234;
    step();
    b8.wr_en = 1'b0;
    total++; if ({b8.rd_valid, b8.data_out} !== {1'b0, 16'h0055}) begin bad++; $display("FAIL lat_nowrite got=%h want=00055", {b8.rd_valid, b8.data_out}); end
    b8.rd_en = 1'b1;
    step();
    b8.rd_en = 1'b0;
    total++; if ({b8.rd_valid, b8.data_out} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL lat_read got=%h want=11234", {b8.rd_valid, b8.data_out}); end
    step();
    total++; if ({b8.rd_valid, b8.data_out} !== {1'b0, 16'h1234}) begin bad++; $display("FAIL lat_hold got=%h want=01234", {b8.rd_valid, b8.data_out}); end
  endtask
`endif

  task automatic test_wrap();
    logic [15:0] exp;
    for (int k = 0; k < 20; k++) begin
      exp = 16'h0100 + 16'(k);
      b6.wr_en = 1'b1; b6.data_in = exp;
      step();
      b6.wr_en = 1'b0;
      total++; if ({b6.count, b6.full, b6.almostfull, b6.almostempty} !== {3'd1, 3'b001}) begin bad++; $display("FAIL wrap_w[%0d] got=%b want=001001", k, {b6.count, b6.full, b6.almostfull, b6.almostempty}); end
`ifdef FIFO_FWFT_EN
      total++; if (b6.data_out !== exp) begin bad++; $display("FAIL wrap_r[%0d] got=%h want=%h", k, b6.data_out, exp); end
      b6.rd_en = 1'b1;
      step();
`else
      b6.rd_en = 1'b1;
      step();
      total++; if ({b6.rd_valid, b6.data_out} !== {1'b1, exp}) begin bad++; $display("FAIL wrap_r[%0d] got=%h want=%h", k, {b6.rd_valid, b6.data_out}, {1'b1, exp}); end
`endif
      b6.rd_en = 1'b0;
      total++; if ({b6.empty, b6.full, b6.almostfull} !== 3'b100) begin bad++; $display("FAIL wrap_e[%0d] got=%b want=100", k, {b6.empty, b6.full, b6.almostfull}); end
    end
    for (int i = 0; i < 6; i++) begin
      b6.wr_en = 1'b1; b6.data_in = 16'h0200 + 16'(i);
      step();
      total++; if ({b6.count, b6.full, b6.almostfull} !== {3'(i + 1), (i == 5), (i >= 4)}) begin bad++; $display("FAIL wfill[%0d] got=%b want=%b", i, {b6.count, b6.full, b6.almostfull}, {3'(i + 1), (i == 5), (i >= 4)}); end
    end
    b6.data_in = 16'h02FF;
    step();
    b6.wr_en = 1'b0;
    total++; if ({b6.overflow, b6.wr_ack, b6.count} !== {2'b10, 3'd6}) begin bad++; $display("FAIL wovf got=%b want=10110", {b6.overflow, b6.wr_ack, b6.count}); end
    for (int i = 0; i < 6; i++) begin
      exp = 16'h0200 + 16'(i);
`ifdef FIFO_FWFT_EN
      total++; if (b6.data_out !== exp) begin bad++; $display("FAIL wdrain[%0d] got=%h want=%h", i, b6.data_out, exp); end
      b6.rd_en = 1'b1;
      step();
`else
      b6.rd_en = 1'b1;
      step();
      total++; if (b6.data_out !== exp) begin bad++; $display("FAIL wdrain[%0d] got=%h want=%h", i, b6.data_out, exp); end
`endif
    end
    b6.rd_en = 1'b0;
    total++; if ({b6.empty, b6.count} !== {1'b1, 3'd0}) begin bad++; $display("FAIL wdrain_empty got=%b want=1000", {b6.empty, b6.count}); end
  endtask

  initial begin
    b8.wr_en = 1'b0; b8.rd_en = 1'b0; b8.data_in = '0;
    b6.wr_en = 1'b0; b6.rd_en = 1'b0; b6.data_in = '0;
    test_reset();
    test_reset_mid();
    test_fill_full();
    test_full_rw();
    test_empty_rw();
`ifdef FIFO_FWFT_EN
    test_fwft();
`else
    test_read_latency();
`endif
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
